// File: rtl/huc6261_cp_arb.sv
// Palette RAM slot arbiter (video > buffered CPU write > CPU prefetch); VID_Q/CPU_RDATA land 1 cycle after RAM read.
// CPU_BUSY on full write buffer or pending prefetch; HUC6261_CP_WBUF2_EN selects a 2-entry buffer (else 1).
module huc6261_cp_arb (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        PCE,
   input  logic [8:0]  VID_A,
   output logic [15:0] VID_Q,
   input  logic        CPU_AWR,
   input  logic        CPU_DWR,
   input  logic        CPU_DRD,
   input  logic [15:0] CPU_DI,
   output logic [15:0] CPU_RDATA,
   output logic        CPU_BUSY,
   output logic [8:0]  RAM_A,
   output logic [15:0] RAM_D,
   output logic        RAM_WE,
   input  logic [15:0] RAM_Q
);

`ifdef HUC6261_CP_WBUF2_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic [8:0]  cpa;
   logic [24:0] wb [DEPTH];
   logic [1:0]  wcnt;
   logic        pend;
   logic        rd_infl;
   logic        rd_stale;
   logic        vid_infl;
   logic        full;
   logic        empty;
   logic        push;
   logic        new_req;
   logic        vid_gnt;
   logic        wr_gnt;
   logic        pre_gnt;

   assign full     = (wcnt == 2'(DEPTH));
   assign empty    = (wcnt == 2'd0);
   assign push     = CPU_DWR & ~full;
   assign new_req  = ~CPU_DWR & (CPU_AWR | CPU_DRD);
   // Video grant is gated by reset so the RAM bus reads all-zero while held in reset.
   assign vid_gnt  = PCE & RESn;
   assign wr_gnt   = ~PCE & ~empty;
   assign pre_gnt  = ~PCE & empty & pend & ~rd_infl;
   assign CPU_BUSY = full | pend;

   always_comb begin
      RAM_A  = '0;
      RAM_D  = '0;
      RAM_WE = 1'b0;
      if (vid_gnt) begin
         RAM_A = VID_A;
      end else if (wr_gnt) begin
         RAM_A  = wb[0][24:16];
         RAM_D  = wb[0][15:0];
         RAM_WE = 1'b1;
      end else if (pre_gnt) begin
         RAM_A = cpa;
      end
   end

   // Head always sits in wb[0]; a pop shifts the rest down and a push fills the first free slot.
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         for (int i = 0; i < DEPTH; i++) wb[i] <= '0;
         wcnt <= '0;
      end else begin
         if (wr_gnt) begin
            for (int i = 0; i < DEPTH - 1; i++) wb[i] <= wb[i+1];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (i == int'(wcnt) - int'(wr_gnt))) wb[i] <= {cpa, CPU_DI};
         end
         wcnt <= wcnt + 2'(push) - 2'(wr_gnt);
      end
   end

   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         cpa       <= '0;
         pend      <= 1'b0;
         rd_infl   <= 1'b0;
         rd_stale  <= 1'b0;
         vid_infl  <= 1'b0;
         VID_Q     <= '0;
         CPU_RDATA <= '0;
      end else begin
         if (push) begin
            cpa <= cpa + 9'd1;
         end else if (new_req) begin
            cpa <= CPU_AWR ? CPU_DI[8:0] : cpa + 9'd1;
         end
         // A pointer change during the grant or latency cycle keeps pend so the new address is fetched.
         if (new_req) begin
            pend <= 1'b1;
         end else if (rd_infl && !rd_stale) begin
            pend <= 1'b0;
         end
         rd_infl  <= pre_gnt;
         rd_stale <= pre_gnt & new_req;
         if (rd_infl) CPU_RDATA <= RAM_Q;
         vid_infl <= vid_gnt;
         if (vid_infl) VID_Q <= RAM_Q;
      end
   end

endmodule

// File: doc/huc6261_cp_arb.md
HUC6261_CP_ARB -- requirements
Module: huc6261_cp_arb

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: RESn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: PCE  in  1  video fetch slot strobe, one CLK wide.
REQ-004 SHALL have: VID_A  in  9  video palette address, valid while PCE=1.
REQ-005 SHALL have: VID_Q  out  16  video palette data.
REQ-006 SHALL have: CPU_AWR  in  1  load CPU address pointer from CPU_DI[8:0].
REQ-007 SHALL have: CPU_DWR  in  1  queue a write of CPU_DI to the pointer address.
REQ-008 SHALL have: CPU_DRD  in  1  consume CPU_RDATA.
REQ-009 SHALL have: CPU_DI  in  16  CPU write data.
REQ-010 SHALL have: CPU_RDATA  out  16  prefetched read data.
REQ-011 SHALL have: CPU_BUSY  out  1  write buffer full or prefetch pending.
REQ-012 SHALL have: RAM_A  out  9, RAM_D  out  16, RAM_WE  out  1, RAM_Q  in  16; single-port synchronous palette RAM with 1-cycle read latency.

Function
REQ-013 SHALL grant the RAM slot each cycle by fixed priority: PCE video read > buffered CPU write > CPU prefetch read > idle.
REQ-014 On a PCE cycle SHALL drive RAM_A=VID_A, RAM_WE=0; SHALL register RAM_Q into VID_Q on the following cycle (VID_Q valid 2 CLK after the PCE edge) and hold it until the next video fetch.
REQ-015 SHALL keep the CPU pointer cpa (9 bit), wrapping 0x1FF -> 0x000.
REQ-016 CPU_DWR SHALL push {cpa, CPU_DI} into the write buffer and increment cpa in the same cycle.
REQ-017 A write grant SHALL drive RAM_A/RAM_D from the buffer head with RAM_WE=1 and pop it.
REQ-018 CPU_AWR SHALL load cpa and set prefetch-pending; a CPU_AWR coincident with CPU_DWR SHALL be ignored in favour of the write.
REQ-019 CPU_DRD SHALL increment cpa and set prefetch-pending; CPU_DRD while prefetch-pending SHALL still increment cpa (data is stale; no error flag).
REQ-020 A prefetch SHALL be granted only when the write buffer is empty (read-after-write coherence); RAM_Q SHALL load into CPU_RDATA one cycle after the grant, clearing prefetch-pending.
REQ-021 A new CPU_AWR/CPU_DRD arriving during a prefetch's latency cycle SHALL leave prefetch-pending set so that the newer address is re-fetched.
REQ-022 CPU_BUSY SHALL be 1 when the buffer is full or prefetch-pending is 1; CPU_DWR while full SHALL be dropped with cpa unchanged.
REQ-023 Simultaneous buffer push and pop SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-024 With PCE asserted every cycle, CPU accesses SHALL stall indefinitely without loss of buffered data.

Reset
REQ-025 On RESn=0: cpa=0, buffer empty, prefetch-pending=0, VID_Q=0, CPU_RDATA=0, RAM_WE=0, RAM_A=0, RAM_D=0, CPU_BUSY=0.
REQ-026 Reset mid-write SHALL discard all buffered writes; a RAM write already granted in that cycle need not be prevented.

Configuration
REQ-027 Macro HUC6261_CP_WBUF2_EN defined: the write buffer is 2 entries deep; undefined: 1 entry deep, and CPU_BUSY asserts as soon as one write is queued.

Verification
REQ-028 Reset, then CPU_AWR DI=0x010, run idle -> RAM read at 0x010, CPU_RDATA = RAM[0x010] after 2 cycles, BUSY falls.
REQ-029 CPU_DWR 0x1234 at cpa=0x1FF while PCE=0 -> RAM write at 0x1FF next cycle, cpa=0x000.
REQ-030 CPU_DWR 0xABCD coincident with PCE=1, VID_A=0x020 -> video read granted first, write at the following non-PCE cycle, VID_Q=RAM[0x020].
REQ-031 Two CPU_DWRs during a PCE=1 stall (WBUF2_EN) -> BUSY=1 after the second, both writes issued in order; the third CPU_DWR is dropped.
REQ-032 CPU_DWR to 0x005 then CPU_AWR 0x005 -> prefetch waits for the write, CPU_RDATA = newly written value.
REQ-033 RESn pulsed low with 2 writes buffered -> no further RAM_WE, all outputs at reset values.
